instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-issue fetch stage with delay-slot redirects, pending redirect under stall, halt on PC 0.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target raises fetch_error and halts.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    localparam int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] instr_addr,
    input  logic [XLEN-1:0] instr_readdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            active,
    output logic            fetch_error
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_target, pend_n;
    logic [XLEN-1:0] instr_q, instr_n;
    logic [XLEN-1:0] ifpc_q, ifpc_n;
    logic            ifv_q, ifv_n;
    logic            active_q, active_n;
    logic            err_q, err_n;
    logic            load_en;
    logic [XLEN-1:0] load_raw;
    logic [XLEN-1:0] load_addr;

    // State and IF register bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            pend_target <= '0;
            instr_q     <= '0;
            ifpc_q      <= '0;
            ifv_q       <= 1'b0;
            active_q    <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_target <= pend_n;
            instr_q     <= instr_n;
            ifpc_q      <= ifpc_n;
            ifv_q       <= ifv_n;
            active_q    <= active_n;
            err_q       <= err_n;
        end
    end

    // Next-state: capture on advance, pick next pc source, divert PC-0 / bad targets into HALT
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_n    = pend_target;
        instr_n   = instr_q;
        ifpc_n    = ifpc_q;
        ifv_n     = ifv_q;
        active_n  = active_q;
        err_n     = err_q;
        load_en   = 1'b0;
        load_raw  = pc + XLEN'(4);
        load_addr = '0;

        case (state)
            RUN, PEND: begin
                if (!stall) begin
                    instr_n = instr_readdata;
                    ifpc_n  = pc;
                    ifv_n   = 1'b1;
                    load_en = 1'b1;
                    if (redirect_valid) begin
                        load_raw = redirect_target;
                    end else if (state == PEND) begin
                        load_raw = pend_target;
                    end
                end else if (redirect_valid) begin
                    pend_n  = redirect_target;
                    state_n = PEND;
                end
            end
            default: begin
                ifv_n    = 1'b0;
                active_n = 1'b0;
            end
        endcase

        load_addr = load_raw & ~XLEN'(3);
        if (load_en) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (load_raw[1:0] != 2'b00) begin
                err_n   = 1'b1;
                state_n = HALT;
            end else
`endif
            if (load_addr == '0) begin
                state_n = HALT;
            end else begin
                pc_n    = load_addr;
                state_n = RUN;
            end
        end
    end

    assign instr_addr  = pc;
    assign if_valid    = ifv_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign active      = active_q;
    assign fetch_error = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_instr_fetch;

    localparam logic [31:0] RV      = 32'hBFC00000;
    localparam logic [31:0] ROM_KEY = 32'h5A5A0F0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instr_addr;
    logic [31:0] instr_readdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        active;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr_readdata = instr_addr ^ ROM_KEY;

    instr_fetch #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_addr     (instr_addr),
        .instr_readdata (instr_readdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .active         (active),
        .fetch_error    (fetch_error)
    );

    // Behavioural model: architectural fetch pointer, optional pending redirect, halted flag
    logic [31:0] m_pc = '0, m_pend = '0, m_instr = '0, m_ifpc = '0;
    bit          m_pending = 0, m_halted = 0, m_v = 0, m_active = 0, m_err = 0;

    function automatic logic [98:0] observed();
        return {if_valid, if_pc, if_instr, active, fetch_error, instr_addr};
    endfunction

    function automatic logic [98:0] predicted();
        return {m_v, m_ifpc, m_instr, m_active, m_err, m_pc};
    endfunction

    task automatic step(input bit r, input bit s, input bit v, input logic [31:0] t);
        logic [31:0] nxt;
        reset = r; stall = s; redirect_valid = v; redirect_target = t;
        @(posedge clk);
        if (r) begin
            m_pc = RV; m_pending = 0; m_pend = '0; m_halted = 0;
            m_v = 0; m_instr = '0; m_ifpc = '0; m_active = 1; m_err = 0;
        end else if (m_halted) begin
            m_v = 0; m_active = 0;
        end else if (!s) begin
            m_instr = m_pc ^ ROM_KEY; m_ifpc = m_pc; m_v = 1;
            nxt = v ? t : (m_pending ? m_pend : m_pc + 32'd4);
            m_pending = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (nxt % 4 != 0) begin
                m_err = 1; m_halted = 1;
            end else
`endif
            begin
                nxt = nxt - (nxt % 4);
                if (nxt == 0) m_halted = 1;
                else m_pc = nxt;
            end
        end else if (v) begin
            m_pending = 1; m_pend = t;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0);
        step(1, 1, 1, 32'h00000123);
    endtask

    task automatic test_reset();
        logic [98:0] exp;
        do_reset();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, RV};
        if (observed() !== exp) begin
            errors++; $display("FAIL reset_state: got %h expected %h", observed(), exp);
        end
        checks++;
    endtask

    task automatic test_linear();
        do_reset();
        step(0, 0, 0, '0);
        if ({if_valid, if_pc, if_instr} !== {1'b1, RV, RV ^ ROM_KEY}) begin
            errors++; $display("FAIL linear_first: got %h expected %h", {if_valid, if_pc, if_instr}, {1'b1, RV, RV ^ ROM_KEY});
        end
        checks++;
        step(0, 0, 0, '0);
        if ({if_pc, active} !== {RV + 32'd4, 1'b1}) begin
            errors++; $display("FAIL linear_second: got %h expected %h", {if_pc, active}, {RV + 32'd4, 1'b1});
        end
        checks++;
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hBFC00004, 32'hBFC00100, 32'hBFC00104};
        do_reset();
        step(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, i == 0, 32'hBFC00100);
            if (if_pc !== exp_pc[i]) begin
                errors++; $display("FAIL redirect_seq%0d: got %h expected %h", i, if_pc, exp_pc[i]);
            end
            checks++;
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        step(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, i == 1, 32'hBFC00200);
            if ({if_valid, if_pc, if_instr, instr_addr} !== {1'b1, RV, RV ^ ROM_KEY, RV + 32'd4}) begin
                errors++; $display("FAIL stall_frozen%0d: got %h expected %h", i,
                    {if_valid, if_pc, if_instr, instr_addr}, {1'b1, RV, RV ^ ROM_KEY, RV + 32'd4});
            end
            checks++;
        end
        step(0, 0, 0, '0);
        if (if_pc !== RV + 32'd4) begin
            errors++; $display("FAIL stall_release: got %h expected %h", if_pc, RV + 32'd4);
        end
        checks++;
        step(0, 0, 0, '0);
        if (if_pc !== 32'hBFC00200) begin
            errors++; $display("FAIL stall_pending_target: got %h expected %h", if_pc, 32'hBFC00200);
        end
        checks++;
    endtask

    task automatic test_pend_rules();
        do_reset();
        step(0, 0, 0, '0);
        step(0, 1, 1, 32'hBFC00400);
        step(0, 1, 1, 32'hBFC00500);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        if (if_pc !== 32'hBFC00500) begin
            errors++; $display("FAIL pend_last_wins: got %h expected %h", if_pc, 32'hBFC00500);
        end
        checks++;
        step(0, 1, 1, 32'hBFC00600);
        step(0, 0, 1, 32'hBFC00700);
        if (if_pc !== 32'hBFC00504) begin
            errors++; $display("FAIL pend_release_slot: got %h expected %h", if_pc, 32'hBFC00504);
        end
        checks++;
        step(0, 0, 0, '0);
        if (if_pc !== 32'hBFC00700) begin
            errors++; $display("FAIL pend_redirect_priority: got %h expected %h", if_pc, 32'hBFC00700);
        end
        checks++;
    endtask

    task automatic test_halt();
        do_reset();
        step(0, 0, 0, '0);
        step(0, 0, 1, 32'h00000000);
        if ({if_valid, if_pc} !== {1'b1, RV + 32'd4}) begin
            errors++; $display("FAIL halt_delay_slot: got %h expected %h", {if_valid, if_pc}, {1'b1, RV + 32'd4});
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'b1, 32'hBFC00800 + 32'(i * 4));
            if ({active, if_valid, if_pc, instr_addr} !== {1'b0, 1'b0, RV + 32'd4, RV + 32'd4}) begin
                errors++; $display("FAIL halt_hold%0d: got %h expected %h", i,
                    {active, if_valid, if_pc, instr_addr}, {1'b0, 1'b0, RV + 32'd4, RV + 32'd4});
            end
            checks++;
        end
    endtask

    task automatic test_misalign();
        do_reset();
        step(0, 0, 0, '0);
        step(0, 0, 1, 32'hBFC00102);
        step(0, 0, 0, '0);
`ifdef FETCH_ALIGN_CHECK_EN
        if ({fetch_error, active} !== 2'b10) begin
            errors++; $display("FAIL misalign_halt: got %b expected %b", {fetch_error, active}, 2'b10);
        end
`else
        if ({if_pc, fetch_error, active} !== {32'hBFC00100, 1'b0, 1'b1}) begin
            errors++; $display("FAIL misalign_mask: got %h expected %h", {if_pc, fetch_error, active}, {32'hBFC00100, 1'b0, 1'b1});
        end
`endif
        checks++;
    endtask

    task automatic test_reset_pend();
        do_reset();
        step(0, 0, 0, '0);
        step(0, 1, 1, 32'hBFC00300);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        if (if_pc !== RV) begin
            errors++; $display("FAIL reset_pend_first: got %h expected %h", if_pc, RV);
        end
        checks++;
        step(0, 0, 0, '0);
        if (if_pc !== RV + 32'd4) begin
            errors++; $display("FAIL reset_pend_second: got %h expected %h", if_pc, RV + 32'd4);
        end
        checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 0, 0, '0);
        step(0, 0, 1, 32'hFFFFFFF8);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        if ({if_pc, active} !== {32'hFFFFFFFC, 1'b1}) begin
            errors++; $display("FAIL wrap_last_word: got %h expected %h", {if_pc, active}, {32'hFFFFFFFC, 1'b1});
        end
        checks++;
        step(0, 0, 0, '0);
        if ({active, if_valid, instr_addr} !== {1'b0, 1'b0, 32'hFFFFFFFC}) begin
            errors++; $display("FAIL wrap_halt: got %h expected %h", {active, if_valid, instr_addr}, {1'b0, 1'b0, 32'hFFFFFFFC});
        end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        int unsigned sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0:       t = 32'h00000000;
                1:       t = 32'hFFFFFFFC;
                2:       t = 32'hBFC00000 | 32'($urandom_range(0, 1023) << 2) | 32'($urandom_range(1, 3));
                default: t = 32'hBFC00000 | 32'($urandom_range(0, 1023) << 2);
            endcase
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 6) == 0, t);
            if (observed() !== predicted()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, observed(), predicted());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_redirect();
        test_stall_redirect();
        test_pend_rules();
        test_halt();
        test_misalign();
        test_reset_pend();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
